// File: rtl/imem_loadable.sv
// Loadable instruction memory: a boot-load stream fills the RAM, then a registered,
// handshaked fetch port serves the sequencer. Define IMEM_PARITY_EN for per-word parity.
module imem_loadable #(
  parameter int unsigned     OP_W    = 16,
  parameter int unsigned     PC_W    = 8,
  parameter int unsigned     DEPTH   = 256,
  parameter logic [OP_W-1:0] FILL_OP = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            reload,
  input  logic            ld_valid,
  output logic            ld_ready,
  input  logic [OP_W-1:0] ld_data,
  input  logic            ld_last,
  output logic            ld_ovf,
  output logic [PC_W:0]   prog_len,
  output logic            fetch_ready,
  input  logic            fetch_req,
  input  logic [PC_W-1:0] fetch_pc,
  output logic [OP_W-1:0] op,
  output logic            op_valid,
`ifdef IMEM_PARITY_EN
  output logic            par_err,
`endif
  output logic            pc_err
);

`ifdef IMEM_PARITY_EN
  localparam int unsigned MemW = OP_W + 1;
`else
  localparam int unsigned MemW = OP_W;
`endif
  localparam int unsigned AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PC_W:0] DepthW = (PC_W + 1)'(DEPTH);

  typedef enum logic {StLoad, StRun} state_e;

  state_e          state_q, state_d;
  logic [PC_W:0]   wptr_q, wptr_d;
  logic [PC_W:0]   prog_len_q, prog_len_d;
  logic            ld_ovf_q, ld_ovf_d;
  logic            op_valid_q, op_valid_d;
  logic            src_ok_q, src_ok_d;
  logic            wr_en, fetch_go, in_range, par_bad;
  logic [MemW-1:0] wr_word;
  logic [MemW-1:0] rd_q;
  logic [MemW-1:0] mem [DEPTH];

  assign in_range = {1'b0, fetch_pc} < prog_len_q;

`ifdef IMEM_PARITY_EN
  logic par_err_q, par_err_d;
  assign wr_word = {^ld_data, ld_data};
  // Stored words carry even parity, so any odd reduction means a corrupted word.
  assign par_bad = src_ok_q & (^rd_q);
  assign par_err = par_err_q | (op_valid_q & par_bad);
  assign par_err_d = reload ? 1'b0 : par_err;
`else
  assign wr_word = ld_data;
  assign par_bad = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    wptr_d     = wptr_q;
    prog_len_d = prog_len_q;
    ld_ovf_d   = ld_ovf_q;
    src_ok_d   = src_ok_q;
    wr_en      = 1'b0;
    fetch_go   = 1'b0;
    unique case (state_q)
      StLoad: begin
        if (reload) begin
          wptr_d   = '0;
          ld_ovf_d = 1'b0;
        end else if (ld_valid) begin
          if (wptr_q < DepthW) begin
            wr_en  = 1'b1;
            wptr_d = wptr_q + 1'b1;
          end else begin
            ld_ovf_d = 1'b1;
          end
          if (ld_last) begin
            prog_len_d = wr_en ? wptr_q + 1'b1 : wptr_q;
            state_d    = StRun;
          end
        end
      end
      StRun: begin
        if (reload) begin
          state_d  = StLoad;
          wptr_d   = '0;
          ld_ovf_d = 1'b0;
        end else if (fetch_req) begin
          fetch_go = 1'b1;
          src_ok_d = in_range;
        end
      end
      default: state_d = StLoad;
    endcase
    op_valid_d = fetch_go;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StLoad;
      wptr_q     <= '0;
      prog_len_q <= '0;
      ld_ovf_q   <= 1'b0;
      op_valid_q <= 1'b0;
      src_ok_q   <= 1'b0;
`ifdef IMEM_PARITY_EN
      par_err_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      wptr_q     <= wptr_d;
      prog_len_q <= prog_len_d;
      ld_ovf_q   <= ld_ovf_d;
      op_valid_q <= op_valid_d;
      src_ok_q   <= src_ok_d;
`ifdef IMEM_PARITY_EN
      par_err_q  <= par_err_d;
`endif
    end
  end

  // Plain RAM with one write and one registered read port, no reset, for block RAM mapping.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wptr_q[AW-1:0]] <= wr_word;
    if (fetch_go && in_range) rd_q <= mem[fetch_pc[AW-1:0]];
  end

  assign ld_ready    = (state_q == StLoad);
  assign fetch_ready = (state_q == StRun);
  assign ld_ovf      = ld_ovf_q;
  assign prog_len    = prog_len_q;
  assign op_valid    = op_valid_q;
  assign op          = (src_ok_q & ~par_bad) ? rd_q[OP_W-1:0] : FILL_OP;
  assign pc_err      = op_valid_q & ~(src_ok_q & ~par_bad);

endmodule

// File: tb/tb_imem_loadable.sv
// Self-checking bench for imem_loadable (DEPTH=8) against an array-based reference model.
module tb_imem_loadable;
  localparam int unsigned OP_W  = 16;
  localparam int unsigned PC_W  = 8;
  localparam int unsigned DEPTH = 8;
  localparam logic [15:0] FILL  = 16'h0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        reload = 1'b0, ld_valid = 1'b0, ld_last = 1'b0, fetch_req = 1'b0;
  logic [15:0] ld_data = '0;
  logic [7:0]  fetch_pc = '0;
  logic        ld_ready, ld_ovf, fetch_ready, op_valid, pc_err;
  logic [8:0]  prog_len;
  logic [15:0] op;
`ifdef IMEM_PARITY_EN
  logic        par_err;
`endif

  int total = 0;
  int bad = 0;

  // Reference model: what a correct memory holds and last returned.
  logic [15:0] m_mem [DEPTH];
  int          m_len = 0;
  bit          m_ovf = 0;
  logic [15:0] m_op = FILL;
  logic [15:0] ld_q [$];

  imem_loadable #(.OP_W(OP_W), .PC_W(PC_W), .DEPTH(DEPTH), .FILL_OP(FILL)) dut (
    .clk(clk), .rst(rst), .reload(reload), .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_data(ld_data), .ld_last(ld_last), .ld_ovf(ld_ovf), .prog_len(prog_len),
    .fetch_ready(fetch_ready), .fetch_req(fetch_req), .fetch_pc(fetch_pc), .op(op),
    .op_valid(op_valid),
`ifdef IMEM_PARITY_EN
    .par_err(par_err),
`endif
    .pc_err(pc_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string name);
    total++;
    if ({ld_ready, ld_ovf, fetch_ready, op_valid, pc_err} !== 5'b10000 ||
        prog_len !== 9'd0 || op !== FILL) begin
      bad++;
      $display("FAIL %s: rdy/ovf/frdy/vld/err=%b%b%b%b%b len=%0d op=%h, need 10000 len=0 op=%h",
               name, ld_ready, ld_ovf, fetch_ready, op_valid, pc_err, prog_len, op, FILL);
    end
  endtask

  // Streams ld_q, optionally with idle gaps, then checks the resulting RUN status.
  task automatic do_load(input string name, input bit gaps);
    int n = ld_q.size();
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        ld_valid = 1'b0;
        tick();
      end
      total++;
      if (ld_ready !== 1'b1) begin
        bad++;
        $display("FAIL %s ld_ready word %0d: got %b need 1", name, i, ld_ready);
      end
      ld_valid = 1'b1;
      ld_data  = ld_q[i];
      ld_last  = (i == n - 1);
      tick();
    end
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    m_len = (n > int'(DEPTH)) ? int'(DEPTH) : n;
    m_ovf = (n > int'(DEPTH));
    for (int i = 0; i < m_len; i++) m_mem[i] = ld_q[i];
    total++;
    if (fetch_ready !== 1'b1 || ld_ready !== 1'b0 || prog_len !== 9'(m_len) ||
        ld_ovf !== m_ovf) begin
      bad++;
      $display("FAIL %s status: frdy=%b rdy=%b len=%0d ovf=%b, need 1 0 %0d %b",
               name, fetch_ready, ld_ready, prog_len, ld_ovf, m_len, m_ovf);
    end
  endtask

  // Issues one fetch (leaves fetch_req high so consecutive calls are back-to-back).
  task automatic fetch_one(input string name, input int pc);
    logic [15:0] exp_op;
    bit          exp_err;
    fetch_req = 1'b1;
    fetch_pc  = 8'(pc);
    tick();
    exp_err = !(pc < m_len);
    exp_op  = exp_err ? FILL : m_mem[pc];
    m_op    = exp_op;
    total++;
    if (op_valid !== 1'b1 || op !== exp_op || pc_err !== exp_err) begin
      bad++;
      $display("FAIL %s pc=%0d: vld=%b op=%h err=%b, need 1 %h %b",
               name, pc, op_valid, op, pc_err, exp_op, exp_err);
    end
  endtask

  task automatic idle_check(input string name);
    fetch_req = 1'b0;
    tick();
    total++;
    if (op_valid !== 1'b0 || pc_err !== 1'b0 || op !== m_op) begin
      bad++;
      $display("FAIL %s idle: vld=%b err=%b op=%h, need 0 0 %h", name, op_valid, pc_err, op, m_op);
    end
  endtask

  task automatic do_reload(input string name, input bit with_fetch, input int pc);
    reload    = 1'b1;
    fetch_req = with_fetch;
    fetch_pc  = 8'(pc);
    tick();
    reload    = 1'b0;
    fetch_req = 1'b0;
    m_ovf     = 0;
    total++;
    if (op_valid !== 1'b0 || ld_ready !== 1'b1 || fetch_ready !== 1'b0 ||
        ld_ovf !== 1'b0 || prog_len !== 9'(m_len)) begin
      bad++;
      $display("FAIL %s reload: vld=%b rdy=%b frdy=%b ovf=%b len=%0d, need 0 1 0 0 %0d",
               name, op_valid, ld_ready, fetch_ready, ld_ovf, prog_len, m_len);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) tick();
    check_reset_values("reset");
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    ld_q = '{16'h1100, 16'h2210, 16'h3320, 16'h4430};
    do_load("basic_load", 1'b0);
    for (int pc = 0; pc < 4; pc++) fetch_one("basic_b2b", pc);
    idle_check("basic");
    fetch_one("basic_oob", 4);
    fetch_one("basic_oob", 255);
    idle_check("basic_oob");
  endtask

  task automatic test_overflow();
    ld_q = {};
    for (int i = 0; i < 10; i++) ld_q.push_back(16'hC000 + 16'(i * 16'h0111));
    do_load("ovf_load", 1'b1);
    for (int pc = 0; pc < 10; pc++) fetch_one("ovf_fetch", pc);
    idle_check("ovf");
  endtask

  task automatic test_reload_fetch();
    do_reload("reload_fetch", 1'b1, 1);
    ld_q = '{16'hAAAA, 16'hBBBB};
    do_load("reload_load", 1'b0);
    fetch_one("reload_fetch", 1);
    fetch_one("reload_fetch", 2);
    fetch_one("reload_fetch", 0);
    idle_check("reload");
  endtask

  task automatic test_async_reset();
    do_reload("async_pre", 1'b0, 0);
    ld_q = '{16'h0101, 16'h0202, 16'h0303, 16'h0404, 16'h0505};
    for (int i = 0; i < 2; i++) begin
      ld_valid = 1'b1;
      ld_data  = ld_q[i];
      tick();
    end
    ld_data = ld_q[2];
    #2 rst = 1'b1;
    #1 check_reset_values("async_reset");
    ld_valid = 1'b0;
    tick();
    rst   = 1'b0;
    m_len = 0;
    m_op  = FILL;
    tick();
    ld_q = '{16'h5A5A};
    do_load("one_word", 1'b0);
    fetch_one("one_word", 0);
    fetch_one("one_word", 1);
    idle_check("one_word");
  endtask

  task automatic test_reload_in_load();
    do_reload("rl_pre", 1'b0, 0);
    ld_valid = 1'b1;
    ld_data  = 16'h1234;
    tick();
    ld_data = 16'h9999;
    ld_last = 1'b1;
    reload  = 1'b1;
    tick();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    reload   = 1'b0;
    total++;
    if (ld_ready !== 1'b1 || fetch_ready !== 1'b0) begin
      bad++;
      $display("FAIL last_vs_reload: rdy=%b frdy=%b, need 1 0", ld_ready, fetch_ready);
    end
    ld_q = '{16'h7001, 16'h7002, 16'h7003};
    do_load("rl_load", 1'b0);
    for (int pc = 0; pc < 4; pc++) fetch_one("rl_fetch", pc);
    idle_check("rl");
  endtask

  task automatic test_random();
    for (int r = 0; r < 6; r++) begin
      do_reload("rand_pre", 1'($urandom_range(0, 1)), int'($urandom_range(0, 7)));
      ld_q = {};
      for (int i = 0, n = int'($urandom_range(1, 10)); i < n; i++)
        ld_q.push_back(16'($urandom));
      do_load("rand_load", 1'b1);
      for (int c = 0; c < 20; c++) begin
        if ($urandom_range(0, 3) == 0) idle_check("rand");
        else if ($urandom_range(0, 3) == 0) fetch_one("rand", int'($urandom_range(0, 255)));
        else fetch_one("rand", int'($urandom_range(0, 9)));
      end
      idle_check("rand_end");
    end
  endtask

`ifdef IMEM_PARITY_EN
  task automatic test_parity();
    do_reload("par_pre", 1'b0, 0);
    ld_q = '{16'h0F0F, 16'h1357};
    do_load("par_load", 1'b0);
    dut.mem[0][0] = ~dut.mem[0][0];
    fetch_req = 1'b1;
    fetch_pc  = 8'd0;
    tick();
    total++;
    if (op !== FILL || pc_err !== 1'b1 || par_err !== 1'b1 || op_valid !== 1'b1) begin
      bad++;
      $display("FAIL parity_hit: op=%h err=%b par=%b vld=%b", op, pc_err, par_err, op_valid);
    end
    m_op = FILL;
    fetch_one("par_clean", 1);
    idle_check("par");
    total++;
    if (par_err !== 1'b1) begin
      bad++;
      $display("FAIL parity_sticky: got %b need 1", par_err);
    end
    do_reload("par_clr", 1'b0, 0);
    total++;
    if (par_err !== 1'b0) begin
      bad++;
      $display("FAIL parity_clear: got %b need 0", par_err);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    do_reload("to_ovf", 1'b0, 0);
    test_overflow();
    test_reload_fetch();
    test_async_reset();
    test_reload_in_load();
    test_random();
`ifdef IMEM_PARITY_EN
    test_parity();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
